mips_decode_pipe: RTL and testbench
===================================

# mips_decode_pipe

Registered, parametrised instruction-decode stage for the pipelined MIPS datapath. It accepts raw 32-bit instructions over a valid/ready handshake and emits one registered control bundle ("micro-op") per cycle. Instructions that need memory then ALU (ADDM) are cracked into two micro-ops. A load-use scoreboard inserts bubbles, and a synchronous flush kills in-flight work. It sits between fetch and execute, replacing the combinational decoder in the single-cycle machine.

## Interface
- LOAD_LATENCY, default 1: number of micro-op slots after a load during which its destination register is unavailable (range 1–4).
- REG_W, default 5: register-specifier width.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_inst holds an instruction.
- in_ready  out  1  stage accepts in_inst this cycle.
- in_inst  in  32  MIPS instruction word.
- flush  in  1  synchronous kill of the output register, ADDM sequence and scoreboard.
- out_valid  out  1  output bundle is valid.
- out_ready  in  1  execute consumes the bundle.
- out_uop  out  2  0 NORMAL, 1 ADDM_LD, 2 ADDM_ADD.
- out_alu_op  out  3  ALU operation code (shared package).
- out_alu_src2  out  2  0 reg rt, 1 sign-ext imm, 2 zero-ext imm, 3 mem temp.
- out_writeenable, out_rd_src, out_except, out_jr  out  1 each  register write; destination rt(1)/rd(0); illegal instruction; jump-register.
- out_branch  out  2  0 none, 1 BEQ, 2 BNE, 3 J.
- out_mem_read, out_word_we, out_byte_we, out_byte_load, out_slt, out_lui  out  1 each  memory and special-path controls.
- out_rs, out_rt, out_rd  out  REG_W  register specifiers.
- out_imm  out  16  immediate field.

## Operation
- FSM states:
  - RUN: decode in_inst.
  - ADDM2: issue the second half of ADDM.
- Input rules:
  - adv = !out_valid || out_ready.
  - in_ready = (state==RUN) && adv && !hazard && !flush.
  - Accept = in_valid && in_ready.
- RUN, accept of a non-ADDM instruction: load its NORMAL decode into the output register.
- RUN, accept of ADDM:
  - Load ADDM_LD (mem_read=1, address from rt, result to temp, writeenable=0).
  - Latch rs/rd/imm; go to ADDM2.
- ADDM2 with adv: load ADDM_ADD (alu_op=ADD, alu_src2=3, writeenable=1, rd_src=0), then go to RUN. No input is accepted while in ADDM2.
- Scoreboard sb[0..LOAD_LATENCY-1], each entry REG_W bits; sb[0] describes the bundle in the output register.
  - On every adv cycle the entries shift by one.
  - The shifted-in value is the destination of a loaded LW/LBU (rt), or 0 for anything else, including bubbles.
- Hazard: asserted when in_valid and a used source (rs; rt for R-type, BEQ/BNE, SW/SB) equals a nonzero sb entry.
  - On an adv cycle with a hazard, the output register loads a bubble (out_valid=0).
- Illegal opcode/funct:
  - Bundle with out_except=1.
  - writeenable, mem_read, word_we and byte_we all forced to 0.
  - Issued normally with uop NORMAL.
- Flush:
  - Has priority over everything.
  - Next edge: out_valid=0, sb cleared, state=RUN.
  - Flush in ADDM2 drops ADDM_ADD.
- Output register holds stable while out_valid && !out_ready.

## Timing
- Reset (asynchronous assert, synchronous deassert at the clock):
  - out_valid=0; every out_* field=0; state=RUN; sb all 0.
  - in_ready=1 in the first cycle after reset, if out_ready and no flush.
- Latency: instruction accepted at edge N appears on out_* after edge N; no combinational path from in_inst to out_*.
- Throughput: 1 instruction/cycle; ADDM occupies 2 issue slots.
- Load-use with LOAD_LATENCY=L: a dependent instruction immediately after a load issues after exactly L bubbles, assuming out_ready=1 throughout.
- Backpressure: in_ready follows out_ready combinationally; bubbles do not advance while adv=0.

## Structure
- Shared package mips_defines: opcode and funct constants (incl. OP0_ADDM), ALU op codes, uop codes, branch codes, alu_src2 codes.
- Sub-module mips_decode_comb: purely combinational instruction → control bundle (NORMAL form), instanced once.
- FSM, ADDM cracking, scoreboard and handshake live in the top module.

## Test plan
- Reset, then add $3,$1,$2 (0x00221820), out_ready=1:
  - in_ready=1.
  - Next cycle out_valid=1, alu_op=ADD, writeenable=1, rd_src=0, out_rd=3.
- lw $5,0($1) (0x8C250000) then add $6,$5,$2 (0x00A23020), L=1:
  - One bubble cycle (out_valid=0, in_ready=0).
  - Then the add issues. With L=2, two bubbles.
- addm $4,$1,$2 (0x0022202C):
  - Two consecutive bundles: uop=1 with mem_read=1 and out_rt=2; then uop=2 with alu_src2=3 and out_rd=4.
  - in_ready=0 during the second.
- 0xFC000000:
  - out_except=1.
  - writeenable=word_we=byte_we=mem_read=0.
- out_ready=0 for 3 cycles with a valid bundle: bundle held unchanged, in_ready=0; resumes on release.
- Flush asserted in ADDM2; separately, reset asserted mid-ADDM:
  - Flush: out_valid=0 next cycle, no ADDM_ADD emitted, sb cleared.
  - Reset: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_decode_pipe_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants, control codes and
// the per-micro-op control bundle carried by the decode stage.
package mips_defines;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] OP0_ADDM = 6'h2C;

   typedef enum logic [2:0] {
      ALU_AND = 3'd0,
      ALU_OR  = 3'd1,
      ALU_ADD = 3'd2,
      ALU_SUB = 3'd6
   } alu_op_e;

   typedef enum logic [1:0] {
      UOP_NORMAL   = 2'd0,
      UOP_ADDM_LD  = 2'd1,
      UOP_ADDM_ADD = 2'd2
   } uop_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_BEQ  = 2'd1,
      BR_BNE  = 2'd2,
      BR_J    = 2'd3
   } branch_e;

   typedef enum logic [1:0] {
      SRC2_RT   = 2'd0,
      SRC2_SEXT = 2'd1,
      SRC2_ZEXT = 2'd2,
      SRC2_MEM  = 2'd3
   } src2_e;

   typedef struct packed {
      uop_e    uop;
      alu_op_e alu_op;
      src2_e   alu_src2;
      logic    writeenable;
      logic    rd_src;
      logic    exc;
      logic    jr;
      branch_e branch;
      logic    mem_read;
      logic    word_we;
      logic    byte_we;
      logic    byte_load;
      logic    slt;
      logic    lui;
   } ctrl_t;

endpackage

// File: rtl/mips_decode_comb.sv
// Combinational opcode/funct decoder producing the NORMAL-form control bundle
// plus the side information the pipeline stage needs (ADDM, rt use, loads).
module mips_decode_comb
   import mips_defines::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output ctrl_t      o_ctrl,
   output logic       o_is_addm,
   output logic       o_uses_rt,
   output logic       o_is_load
);

   ctrl_t w_ctrl;
   logic  w_illegal;

   always_comb begin
      w_ctrl    = '0;
      w_illegal = 1'b0;
      o_is_addm = 1'b0;
      o_uses_rt = 1'b0;
      o_is_load = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            o_uses_rt          = 1'b1;
            w_ctrl.writeenable = 1'b1;
            case (i_funct)
               FN_ADD:   w_ctrl.alu_op = ALU_ADD;
               FN_SUB:   w_ctrl.alu_op = ALU_SUB;
               FN_AND:   w_ctrl.alu_op = ALU_AND;
               FN_OR:    w_ctrl.alu_op = ALU_OR;
               FN_SLT: begin
                  w_ctrl.alu_op = ALU_SUB;
                  w_ctrl.slt    = 1'b1;
               end
               FN_JR: begin
                  w_ctrl.writeenable = 1'b0;
                  w_ctrl.jr          = 1'b1;
               end
               OP0_ADDM: begin
                  w_ctrl.alu_op = ALU_ADD;
                  o_is_addm     = 1'b1;
               end
               default:  w_illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_SLTI: begin
            w_ctrl.writeenable = 1'b1;
            w_ctrl.rd_src      = 1'b1;
            w_ctrl.alu_src2    = SRC2_SEXT;
            w_ctrl.alu_op      = (i_opcode == OP_SLTI) ? ALU_SUB : ALU_ADD;
            w_ctrl.slt         = (i_opcode == OP_SLTI);
         end
         OP_ANDI, OP_ORI, OP_LUI: begin
            w_ctrl.writeenable = 1'b1;
            w_ctrl.rd_src      = 1'b1;
            w_ctrl.alu_src2    = SRC2_ZEXT;
            w_ctrl.alu_op      = (i_opcode == OP_ORI) ? ALU_OR : ALU_AND;
            w_ctrl.lui         = (i_opcode == OP_LUI);
         end
         OP_LW, OP_LBU: begin
            w_ctrl.writeenable = 1'b1;
            w_ctrl.rd_src      = 1'b1;
            w_ctrl.alu_src2    = SRC2_SEXT;
            w_ctrl.alu_op      = ALU_ADD;
            w_ctrl.mem_read    = 1'b1;
            w_ctrl.byte_load   = (i_opcode == OP_LBU);
            o_is_load          = 1'b1;
         end
         OP_SW, OP_SB: begin
            o_uses_rt       = 1'b1;
            w_ctrl.alu_src2 = SRC2_SEXT;
            w_ctrl.alu_op   = ALU_ADD;
            w_ctrl.word_we  = (i_opcode == OP_SW);
            w_ctrl.byte_we  = (i_opcode == OP_SB);
         end
         OP_BEQ, OP_BNE: begin
            o_uses_rt     = 1'b1;
            w_ctrl.alu_op = ALU_SUB;
            w_ctrl.branch = (i_opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
         end
         OP_J:    w_ctrl.branch = BR_J;
         default: w_illegal = 1'b1;
      endcase

      o_ctrl = w_ctrl;
      // Illegal encodings still issue, but with every side effect suppressed.
      if (w_illegal) begin
         o_ctrl     = '0;
         o_ctrl.exc = 1'b1;
         o_is_addm  = 1'b0;
         o_is_load  = 1'b0;
      end
   end

endmodule

// File: rtl/mips_decode_pipe.sv
// Registered decode stage: valid/ready handshake, ADDM cracking into two
// micro-ops, load-use scoreboard with bubble insertion, synchronous flush.
module mips_decode_pipe
   import mips_defines::*;
#(
   parameter int unsigned LOAD_LATENCY = 1,
   parameter int unsigned REG_W        = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_uop,
   output logic [2:0]       out_alu_op,
   output logic [1:0]       out_alu_src2,
   output logic             out_writeenable,
   output logic             out_rd_src,
   output logic             out_except,
   output logic             out_jr,
   output logic [1:0]       out_branch,
   output logic             out_mem_read,
   output logic             out_word_we,
   output logic             out_byte_we,
   output logic             out_byte_load,
   output logic             out_slt,
   output logic             out_lui,
   output logic [REG_W-1:0] out_rs,
   output logic [REG_W-1:0] out_rt,
   output logic [REG_W-1:0] out_rd,
   output logic [15:0]      out_imm
);

   typedef enum logic {ST_RUN, ST_ADDM2} state_e;

   state_e           r_state, w_state_nxt;
   logic             r_valid;
   ctrl_t            r_ctrl;
   logic [REG_W-1:0] r_rs, r_rt, r_rd;
   logic [15:0]      r_imm;
   logic [REG_W-1:0] r_addm_rs, r_addm_rd;
   logic [15:0]      r_addm_imm;
   logic [REG_W-1:0] r_sb [LOAD_LATENCY];

   ctrl_t            w_dec_ctrl, w_ld_ctrl, w_add_ctrl;
   logic             w_is_addm, w_uses_rt, w_is_load;
   logic [REG_W-1:0] w_rs_f, w_rt_f, w_rd_f, w_sb_in;
   logic             w_adv, w_hazard, w_accept, w_issue_dec, w_issue_add;

   mips_decode_comb u_dec (
      .i_opcode  (in_inst[31:26]),
      .i_funct   (in_inst[5:0]),
      .o_ctrl    (w_dec_ctrl),
      .o_is_addm (w_is_addm),
      .o_uses_rt (w_uses_rt),
      .o_is_load (w_is_load)
   );

   assign w_rs_f   = REG_W'(in_inst[25:21]);
   assign w_rt_f   = REG_W'(in_inst[20:16]);
   assign w_rd_f   = REG_W'(in_inst[15:11]);

   assign w_adv    = !r_valid || out_ready;
   assign in_ready = (r_state == ST_RUN) && w_adv && !w_hazard && !flush;
   assign w_accept = in_valid && in_ready;
   assign w_sb_in  = (w_accept && w_is_load) ? w_rt_f : '0;

   always_comb begin
      w_hazard = 1'b0;
      for (int unsigned i = 0; i < LOAD_LATENCY; i++) begin
         if ((r_sb[i] != '0) &&
             ((r_sb[i] == w_rs_f) || (w_uses_rt && (r_sb[i] == w_rt_f))))
            w_hazard = 1'b1;
      end
      w_hazard = w_hazard && in_valid;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt          = r_state;
      w_issue_dec          = 1'b0;
      w_issue_add          = 1'b0;
      w_ld_ctrl            = '0;
      w_ld_ctrl.uop        = UOP_ADDM_LD;
      w_ld_ctrl.mem_read   = 1'b1;
      w_add_ctrl           = '0;
      w_add_ctrl.uop       = UOP_ADDM_ADD;
      w_add_ctrl.alu_op    = ALU_ADD;
      w_add_ctrl.alu_src2  = SRC2_MEM;
      w_add_ctrl.writeenable = 1'b1;
      if (flush) begin
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_accept) begin
                  w_issue_dec = 1'b1;
                  if (w_is_addm) w_state_nxt = ST_ADDM2;
               end
            end
            ST_ADDM2: begin
               if (w_adv) begin
                  w_issue_add = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid    <= 1'b0;
         r_ctrl     <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_imm      <= '0;
         r_addm_rs  <= '0;
         r_addm_rd  <= '0;
         r_addm_imm <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_adv) begin
         if (w_issue_add) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_add_ctrl;
            r_rs    <= r_addm_rs;
            r_rt    <= '0;
            r_rd    <= r_addm_rd;
            r_imm   <= r_addm_imm;
         end else if (w_issue_dec) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_is_addm ? w_ld_ctrl : w_dec_ctrl;
            r_rs    <= w_rs_f;
            r_rt    <= w_rt_f;
            r_rd    <= w_rd_f;
            r_imm   <= in_inst[15:0];
            if (w_is_addm) begin
               r_addm_rs  <= w_rs_f;
               r_addm_rd  <= w_rd_f;
               r_addm_imm <= in_inst[15:0];
            end
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   // sb[0] tracks the bundle now in the output register; bubbles shift in 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < LOAD_LATENCY; i++) r_sb[i] <= '0;
      end else if (flush) begin
         for (int unsigned i = 0; i < LOAD_LATENCY; i++) r_sb[i] <= '0;
      end else if (w_adv) begin
         r_sb[0] <= w_sb_in;
         for (int unsigned i = 1; i < LOAD_LATENCY; i++) r_sb[i] <= r_sb[i-1];
      end
   end

   assign out_valid       = r_valid;
   assign out_uop         = r_ctrl.uop;
   assign out_alu_op      = r_ctrl.alu_op;
   assign out_alu_src2    = r_ctrl.alu_src2;
   assign out_writeenable = r_ctrl.writeenable;
   assign out_rd_src      = r_ctrl.rd_src;
   assign out_except      = r_ctrl.exc;
   assign out_jr          = r_ctrl.jr;
   assign out_branch      = r_ctrl.branch;
   assign out_mem_read    = r_ctrl.mem_read;
   assign out_word_we     = r_ctrl.word_we;
   assign out_byte_we     = r_ctrl.byte_we;
   assign out_byte_load   = r_ctrl.byte_load;
   assign out_slt         = r_ctrl.slt;
   assign out_lui         = r_ctrl.lui;
   assign out_rs          = r_rs;
   assign out_rt          = r_rt;
   assign out_rd          = r_rd;
   assign out_imm         = r_imm;

endmodule

// File: tb/tb_mips_decode_pipe.sv
// Directed bench for mips_decode_pipe: decode table plus load-use, ADDM,
// backpressure, flush and reset sequences on LOAD_LATENCY=1 and =2 instances.
module tb_mips_decode_pipe;

   logic        clock, reset;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [1:0]  out_uop, out_alu_src2, out_branch;
   logic [2:0]  out_alu_op;
   logic        out_writeenable, out_rd_src, out_except, out_jr, out_mem_read;
   logic        out_word_we, out_byte_we, out_byte_load, out_slt, out_lui;
   logic [4:0]  out_rs, out_rt, out_rd;
   logic [15:0] out_imm;

   logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [31:0] b_in_inst;
   logic [1:0]  b_out_uop, b_out_alu_src2, b_out_branch;
   logic [2:0]  b_out_alu_op;
   logic        b_out_writeenable, b_out_rd_src, b_out_except, b_out_jr, b_out_mem_read;
   logic        b_out_word_we, b_out_byte_we, b_out_byte_load, b_out_slt, b_out_lui;
   logic [4:0]  b_out_rs, b_out_rt, b_out_rd;
   logic [15:0] b_out_imm;

   logic [18:0] ctl, b_ctl;
   logic [50:0] all_o, b_all;
   assign ctl   = {out_uop, out_alu_op, out_alu_src2, out_writeenable, out_rd_src,
                   out_except, out_jr, out_branch, out_mem_read, out_word_we,
                   out_byte_we, out_byte_load, out_slt, out_lui};
   assign b_ctl = {b_out_uop, b_out_alu_op, b_out_alu_src2, b_out_writeenable, b_out_rd_src,
                   b_out_except, b_out_jr, b_out_branch, b_out_mem_read, b_out_word_we,
                   b_out_byte_we, b_out_byte_load, b_out_slt, b_out_lui};
   assign all_o = {out_valid, ctl, out_rs, out_rt, out_rd, out_imm};
   assign b_all = {b_out_valid, b_ctl, b_out_rs, b_out_rt, b_out_rd, b_out_imm};

   mips_decode_pipe #(.LOAD_LATENCY(1), .REG_W(5)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_uop(out_uop), .out_alu_op(out_alu_op), .out_alu_src2(out_alu_src2),
      .out_writeenable(out_writeenable), .out_rd_src(out_rd_src), .out_except(out_except),
      .out_jr(out_jr), .out_branch(out_branch), .out_mem_read(out_mem_read),
      .out_word_we(out_word_we), .out_byte_we(out_byte_we), .out_byte_load(out_byte_load),
      .out_slt(out_slt), .out_lui(out_lui), .out_rs(out_rs), .out_rt(out_rt),
      .out_rd(out_rd), .out_imm(out_imm)
   );

   mips_decode_pipe #(.LOAD_LATENCY(2), .REG_W(5)) dut2 (
      .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_inst(b_in_inst), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_uop(b_out_uop), .out_alu_op(b_out_alu_op), .out_alu_src2(b_out_alu_src2),
      .out_writeenable(b_out_writeenable), .out_rd_src(b_out_rd_src), .out_except(b_out_except),
      .out_jr(b_out_jr), .out_branch(b_out_branch), .out_mem_read(b_out_mem_read),
      .out_word_we(b_out_word_we), .out_byte_we(b_out_byte_we), .out_byte_load(b_out_byte_load),
      .out_slt(b_out_slt), .out_lui(b_out_lui), .out_rs(b_out_rs), .out_rt(b_out_rt),
      .out_rd(b_out_rd), .out_imm(b_out_imm)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // f = {we, rd_src, except, jr, mem_read, word_we, byte_we, byte_load, slt, lui}
   function automatic logic [18:0] mk(input logic [1:0] uop, input logic [2:0] alu,
                                      input logic [1:0] src2, input logic [1:0] br,
                                      input logic [9:0] f);
      return {uop, alu, src2, f[9:6], br, f[5:0]};
   endfunction

   typedef struct packed {
      logic [31:0] inst;
      logic [18:0] ctl;
   } vec_t;

   localparam int NV = 20;
   vec_t vt [NV];

   localparam logic [31:0] I_ADD   = 32'h00221820;
   localparam logic [31:0] I_SUB   = 32'h00853822;
   localparam logic [31:0] I_LW    = 32'h8C250000;
   localparam logic [31:0] I_DEP   = 32'h00A23020;
   localparam logic [31:0] I_ADDM  = 32'h0022202C;

   initial begin
      logic [31:0] iv;
      int          bub;
      bit          got;

      vt[0]  = {I_ADD,          mk(2'd0, 3'd2, 2'd0, 2'd0, 10'b1000_000000)};
      vt[1]  = {I_SUB,          mk(2'd0, 3'd6, 2'd0, 2'd0, 10'b1000_000000)};
      vt[2]  = {32'h0022402A,   mk(2'd0, 3'd6, 2'd0, 2'd0, 10'b1000_000010)};
      vt[3]  = {32'h00224824,   mk(2'd0, 3'd0, 2'd0, 2'd0, 10'b1000_000000)};
      vt[4]  = {32'h00225025,   mk(2'd0, 3'd1, 2'd0, 2'd0, 10'b1000_000000)};
      vt[5]  = {32'h03E00008,   mk(2'd0, 3'd0, 2'd0, 2'd0, 10'b0001_000000)};
      vt[6]  = {32'h2022FFFF,   mk(2'd0, 3'd2, 2'd1, 2'd0, 10'b1100_000000)};
      vt[7]  = {32'h302200F0,   mk(2'd0, 3'd0, 2'd2, 2'd0, 10'b1100_000000)};
      vt[8]  = {32'h34220F0F,   mk(2'd0, 3'd1, 2'd2, 2'd0, 10'b1100_000000)};
      vt[9]  = {32'h3C031234,   mk(2'd0, 3'd0, 2'd2, 2'd0, 10'b1100_000001)};
      vt[10] = {I_LW,           mk(2'd0, 3'd2, 2'd1, 2'd0, 10'b1100_100000)};
      vt[11] = {32'h90260004,   mk(2'd0, 3'd2, 2'd1, 2'd0, 10'b1100_100100)};
      vt[12] = {32'hAC250008,   mk(2'd0, 3'd2, 2'd1, 2'd0, 10'b0000_010000)};
      vt[13] = {32'hA0250008,   mk(2'd0, 3'd2, 2'd1, 2'd0, 10'b0000_001000)};
      vt[14] = {32'h10220003,   mk(2'd0, 3'd6, 2'd0, 2'd1, 10'b0000_000000)};
      vt[15] = {32'h14220003,   mk(2'd0, 3'd6, 2'd0, 2'd2, 10'b0000_000000)};
      vt[16] = {32'h08000010,   mk(2'd0, 3'd0, 2'd0, 2'd3, 10'b0000_000000)};
      vt[17] = {32'h2822FFFF,   mk(2'd0, 3'd6, 2'd1, 2'd0, 10'b1100_000010)};
      vt[18] = {32'hFC000000,   mk(2'd0, 3'd0, 2'd0, 2'd0, 10'b0010_000000)};
      vt[19] = {32'h0022183F,   mk(2'd0, 3'd0, 2'd0, 2'd0, 10'b0010_000000)};

      reset = 1'b0; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_inst = '0; b_flush = 1'b0; b_out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_outputs", 64'(all_o), 64'(0));
      chk("reset_outputs_l2", 64'(b_all), 64'(0));
      reset = 1'b1;
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'(1));

      // Decode table, one instruction followed by an idle slot
      for (int i = 0; i < NV; i++) begin
         iv = vt[i].inst;
         in_inst = iv; in_valid = 1'b1;
         #1;
         chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(1));
         @(posedge clock); #1;
         in_valid = 1'b0;
         chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(1));
         chk($sformatf("tbl%0d_ctl", i), 64'(ctl), 64'(vt[i].ctl));
         chk($sformatf("tbl%0d_fields", i), 64'({out_rs, out_rt, out_rd, out_imm}),
             64'({iv[25:21], iv[20:16], iv[15:11], iv[15:0]}));
         @(posedge clock); #1;
      end

      // Load-use, LOAD_LATENCY=1
      in_inst = I_LW; in_valid = 1'b1;
      @(posedge clock); #1;
      chk("lu1_load_issued", 64'({out_valid, out_mem_read, out_rt}), 64'({1'b1, 1'b1, 5'd5}));
      in_inst = I_DEP;
      #1;
      bub = 0; got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         if (in_ready) got = 1'b1;
         else begin bub++; @(posedge clock); #1; end
      end
      chk("lu1_bubbles", 64'(bub), 64'(1));
      chk("lu1_bubble_valid", 64'(out_valid), 64'(0));
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("lu1_dep_issued", 64'({out_valid, out_rd, out_alu_op}), 64'({1'b1, 5'd6, 3'd2}));
      @(posedge clock); #1;

      // ADDM cracking
      in_inst = I_ADDM; in_valid = 1'b1;
      #1;
      chk("addm_in_ready", 64'(in_ready), 64'(1));
      @(posedge clock); #1;
      in_inst = I_ADD;
      chk("addm_ld", 64'({out_valid, out_uop, out_mem_read, out_writeenable, out_rt}),
          64'({1'b1, 2'd1, 1'b1, 1'b0, 5'd2}));
      chk("addm2_in_ready", 64'(in_ready), 64'(0));
      @(posedge clock); #1;
      chk("addm_add", 64'({out_valid, out_uop, out_alu_op, out_alu_src2, out_writeenable,
                           out_rd_src, out_rs, out_rd}),
          64'({1'b1, 2'd2, 3'd2, 2'd3, 1'b1, 1'b0, 5'd1, 5'd4}));
      chk("addm_after_ready", 64'(in_ready), 64'(1));
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("addm_next", 64'({out_valid, out_uop, out_rd}), 64'({1'b1, 2'd0, 5'd3}));
      @(posedge clock); #1;

      // Backpressure: hold for three cycles, then release
      in_inst = I_ADD; in_valid = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0; in_inst = I_SUB;
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         chk($sformatf("bp_hold%0d", k), 64'({out_valid, ctl, out_rd}),
             64'({1'b1, vt[0].ctl, 5'd3}));
         chk($sformatf("bp_ready%0d", k), 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(in_ready), 64'(1));
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("bp_resume", 64'({out_valid, ctl, out_rd}), 64'({1'b1, vt[1].ctl, 5'd7}));
      @(posedge clock); #1;

      // Flush while in ADDM2 drops the second half
      in_inst = I_ADDM; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0; flush = 1'b1;
      chk("fl_ld", 64'({out_valid, out_uop}), 64'({1'b1, 2'd1}));
      #1;
      chk("fl_in_ready", 64'(in_ready), 64'(0));
      @(posedge clock); #1;
      flush = 1'b0;
      chk("fl_valid0", 64'(out_valid), 64'(0));
      @(posedge clock); #1;
      chk("fl_no_addm_add", 64'(out_valid), 64'(0));
      chk("fl_state_run", 64'(in_ready), 64'(1));

      // Load-use, LOAD_LATENCY=2
      b_in_inst = I_LW; b_in_valid = 1'b1;
      @(posedge clock); #1;
      b_in_inst = I_DEP;
      #1;
      bub = 0; got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         if (b_in_ready) got = 1'b1;
         else begin bub++; @(posedge clock); #1; end
      end
      chk("lu2_bubbles", 64'(bub), 64'(2));
      chk("lu2_bubble_valid", 64'(b_out_valid), 64'(0));
      @(posedge clock); #1;
      b_in_valid = 1'b0;
      chk("lu2_dep_issued", 64'({b_out_valid, b_out_rd}), 64'({1'b1, 5'd6}));
      @(posedge clock); #1;

      // Flush clears the scoreboard: dependent instruction accepted at once
      b_in_inst = I_LW; b_in_valid = 1'b1;
      @(posedge clock); #1;
      b_in_valid = 1'b0; b_flush = 1'b1;
      @(posedge clock); #1;
      b_flush = 1'b0; b_in_inst = I_DEP; b_in_valid = 1'b1;
      #1;
      chk("fl_sb_cleared", 64'(b_in_ready), 64'(1));
      @(posedge clock); #1;
      b_in_valid = 1'b0;
      chk("fl_sb_dep_issued", 64'({b_out_valid, b_out_rd}), 64'({1'b1, 5'd6}));
      @(posedge clock); #1;

      // Asynchronous reset in the middle of an ADDM
      in_inst = I_ADDM; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("rst_mid_ld", 64'({out_valid, out_uop}), 64'({1'b1, 2'd1}));
      #2;
      reset = 1'b0;
      #1;
      chk("rst_async_outputs", 64'(all_o), 64'(0));
      chk("rst_async_outputs_l2", 64'(b_all), 64'(0));
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rst_no_addm_add", 64'(out_valid), 64'(0));
      chk("rst_state_run", 64'(in_ready), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
